// File: rtl/aes_result_capture_if.sv
// Byte-wide valid/ready stream carrying captured AES result blocks.
interface aes_result_capture_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/aes_result_capture.sv
// Snoops stores into a 16-byte result window, queues 128-bit blocks, streams bytes.
// Define AES_CAP_MSB_FIRST_EN to send byte 15 of each block first.
module aes_result_capture #(
   parameter int          VLEN     = 128,
   parameter logic [31:0] WIN_BASE = 32'h0000_0100,
   parameter int          DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [31:0]             addr,
   input  logic [VLEN-1:0]         wdata,
   input  logic [3:0]              wmem,
   input  logic                    vector,
   aes_result_capture_if.master    stream,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LONE = (AW+1)'(1);
   localparam logic [AW-1:0] PONE = AW'(1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e        state_q, state_d;
   logic          hit, vec_push, word_wr;
   logic          push, push_ok, pop, load, adv;
   logic [127:0]  asm_q, asm_nxt, blk, cur_q;
   logic [3:0]    mask_q, mask_nxt, idx_q, idx_sel;
   logic [127:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign hit      = (wmem != 4'h0) && (addr[31:4] == WIN_BASE[31:4]);
   assign vec_push = hit && vector && (wmem == 4'hF) && (addr[3:0] == 4'h0);
   assign word_wr  = hit && !vector && (wmem == 4'hF) && (addr[1:0] == 2'b00);

   always_comb begin
      asm_nxt  = asm_q;
      mask_nxt = mask_q;
      if (word_wr) begin
         asm_nxt[{addr[3:2], 5'b0} +: 32] = wdata[31:0];
         mask_nxt = mask_q | (4'b0001 << addr[3:2]);
      end
   end

   assign push    = vec_push || (word_wr && (mask_nxt == 4'hF));
   assign blk     = vec_push ? wdata[127:0] : asm_nxt;
   // a pop on the same edge frees the slot the push needs
   assign push_ok = push && ((level != FULL) || pop);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         asm_q  <= '0;
         mask_q <= '0;
      end else if (vec_push) begin
         asm_q  <= '0;
         mask_q <= '0;
      end else if (word_wr) begin
         asm_q  <= asm_nxt;
         mask_q <= (mask_nxt == 4'hF) ? 4'h0 : mask_nxt;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr] <= blk;
            wr_ptr        <= wr_ptr + PONE;
         end
         if (pop) rd_ptr <= rd_ptr + PONE;
         if (push && !push_ok) overflow <= 1'b1;
         unique case ({push_ok, pop})
            2'b10:   level <= level + LONE;
            2'b01:   level <= level - LONE;
            default: level <= level;
         endcase
      end
   end

   always_comb begin
      state_d          = state_q;
      load             = 1'b0;
      adv              = 1'b0;
      pop              = 1'b0;
      stream.out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level != '0) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            stream.out_valid = 1'b1;
            if (stream.out_ready) begin
               adv = 1'b1;
               if (idx_q == 4'hF) begin
                  pop     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cur_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cur_q <= mem_q[rd_ptr];
            idx_q <= '0;
         end else if (adv) begin
            idx_q <= idx_q + 4'd1;
         end
      end
   end

`ifdef AES_CAP_MSB_FIRST_EN
   assign idx_sel = ~idx_q;
`else
   assign idx_sel = idx_q;
`endif

   assign stream.out_data = (state_q == SEND) ? cur_q[{idx_sel, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_aes_result_capture.sv
// Scoreboard bench for aes_result_capture: randomized stores vs a window/FIFO model.
module tb_aes_result_capture;
   localparam logic [31:0] WIN_BASE = 32'h0000_0100;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] addr;
   logic [127:0] wdata;
   logic [3:0]  wmem;
   logic        vector;
   logic [$clog2(DEPTH):0] level;
   logic        overflow;

   aes_result_capture_if sif ();

   aes_result_capture #(
      .VLEN(128), .WIN_BASE(WIN_BASE), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .clr(clr), .addr(addr), .wdata(wdata), .wmem(wmem),
      .vector(vector), .stream(sif), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int rdy_mode = 1;
   int pushed = 0;
   int done = 0;
   logic [7:0] exp_q [$];
   logic [31:0] lanes [4];
   bit lane_set [4];
   bit m_ovf = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_blk(input logic [127:0] b);
      if (pushed - done >= DEPTH) begin
         m_ovf = 1'b1;
      end else begin
         pushed++;
         for (int i = 0; i < 16; i++) begin
`ifdef AES_CAP_MSB_FIRST_EN
            exp_q.push_back(b[8*(15-i) +: 8]);
`else
            exp_q.push_back(b[8*i +: 8]);
`endif
         end
      end
   endtask

   task automatic model_store(input logic [31:0] a, input logic [127:0] d,
                              input logic [3:0] m, input logic v);
      int off;
      if (m == 4'h0 || a < WIN_BASE || a >= WIN_BASE + 16) return;
      if (m != 4'hF) return;
      off = int'(a - WIN_BASE);
      if (v) begin
         if (off == 0) begin
            push_blk(d);
            for (int i = 0; i < 4; i++) begin
               lanes[i] = '0;
               lane_set[i] = 1'b0;
            end
         end
      end else if (off % 4 == 0) begin
         lanes[off/4] = d[31:0];
         lane_set[off/4] = 1'b1;
         if (lane_set[0] && lane_set[1] && lane_set[2] && lane_set[3]) begin
            push_blk({lanes[3], lanes[2], lanes[1], lanes[0]});
            for (int i = 0; i < 4; i++) lane_set[i] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      pushed = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lanes[i] = '0;
         lane_set[i] = 1'b0;
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [127:0] d,
                           input logic [3:0] m, input logic v);
      addr = a; wdata = d; wmem = m; vector = v;
      model_store(a, d, m, v);
      @(posedge clk); #1;
      addr = '0; wmem = 4'h0; vector = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && level == 0 && !sif.out_valid) break;
      end
      chk({name, "_left"}, exp_q.size(), 0);
      chk({name, "_level"}, level, 0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // sink ready generator
   initial begin
      int ph = 0;
      sif.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         unique case (rdy_mode)
            0: sif.out_ready = 1'b0;
            1: sif.out_ready = 1'b1;
            2: sif.out_ready = 1'($urandom_range(0, 1));
            default: sif.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
         endcase
         ph++;
      end
   end

   // monitor
   initial begin
      bit stalled = 0;
      logic [7:0] held = '0;
      int nbytes = 0;
      forever begin
         @(negedge clk);
         if (clr) begin
            stalled = 0; nbytes = 0; done = 0;
            continue;
         end
         if (stalled) begin
            chk("stall_valid", sif.out_valid, 1);
            chk("stall_data", sif.out_data, held);
         end
         if (sif.out_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", sif.out_data, 'x);
            end else begin
               chk("stream_byte", sif.out_data, exp_q.pop_front());
               nbytes++;
               if (nbytes == 16) begin
                  nbytes = 0;
                  done++;
               end
            end
         end
         stalled = sif.out_valid && !sif.out_ready;
         held = sif.out_data;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clr = 1'b1; addr = '0; wdata = '0; wmem = '0; vector = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", sif.out_valid, 0);
      chk("rst_data", sif.out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // vector store and latency
      do_store(WIN_BASE, 128'h00112233_44556677_8899AABB_CCDDEEFF, 4'hF, 1'b1);
      chk("lat_idle_valid", sif.out_valid, 0);
      chk("lat_level", level, 1);
      @(posedge clk); #1;
      chk("lat_send_valid", sif.out_valid, 1);
      drain("vec");

      // scalar assembly, out-of-order lanes
      do_store(WIN_BASE + 8, 128'hA0A0A0A0, 4'hF, 1'b0);
      chk("scl_l1", level, 0);
      do_store(WIN_BASE + 0, 128'hB1B1B1B1, 4'hF, 1'b0);
      chk("scl_l2", level, 0);
      do_store(WIN_BASE + 12, 128'hC2C2C2C2, 4'hF, 1'b0);
      chk("scl_l3", level, 0);
      do_store(WIN_BASE + 4, 128'hD3D3D3D3, 4'hF, 1'b0);
      chk("scl_l4", level, 1);
      drain("scl");

      // backpressure 1,0,0,1
      rdy_mode = 3;
      do_store(WIN_BASE, rnd128(), 4'hF, 1'b1);
      do_store(WIN_BASE, rnd128(), 4'hF, 1'b1);
      drain("bp");

      // overflow
      rdy_mode = 0;
      repeat (2) @(posedge clk); #1;
      for (int i = 0; i <= DEPTH; i++) do_store(WIN_BASE, rnd128(), 4'hF, 1'b1);
      chk("ovf_level", level, DEPTH);
      chk("ovf_flag", overflow, m_ovf);
      rdy_mode = 1;
      drain("ovf");
      chk("ovf_sticky", overflow, 1);

      // filtering keeps the lane mask intact
      do_store(WIN_BASE + 0, rnd128(), 4'hF, 1'b0);
      do_store(WIN_BASE + 4, rnd128(), 4'hF, 1'b0);
      do_store(WIN_BASE + 8, rnd128(), 4'hF, 1'b0);
      do_store(WIN_BASE + 12, rnd128(), 4'h1, 1'b0);
      chk("flt_byte", level, 0);
      do_store(WIN_BASE + 16, rnd128(), 4'hF, 1'b1);
      chk("flt_vec16", level, 0);
      do_store(WIN_BASE + 14, rnd128(), 4'hF, 1'b0);
      chk("flt_misal", level, 0);
      do_store(WIN_BASE + 12, rnd128(), 4'hF, 1'b0);
      chk("flt_push", level, 1);
      drain("flt");

      // randomized stores with random backpressure
      rdy_mode = 2;
      for (int k = 0; k < 120; k++) begin
         logic [31:0] a;
         logic [3:0] m;
         logic v;
         int kind;
         for (int w = 0; w < 600 && (pushed - done >= DEPTH); w++) @(posedge clk);
         #1;
         if (pushed - done >= DEPTH) begin
            n_tests++; n_fail++;
            $display("FAIL rnd_space: got %0d queued expected < %0d", pushed - done, DEPTH);
         end
         kind = $urandom_range(0, 9);
         m = 4'hF; v = 1'b0;
         a = WIN_BASE + 4 * $urandom_range(0, 3);
         unique case (kind)
            5: begin a = WIN_BASE; v = 1'b1; end
            6: begin m = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'h3; v = 1'($urandom_range(0, 1)); end
            7: a = WIN_BASE + 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
            8: a = ($urandom_range(0, 1) == 0) ? WIN_BASE + 16 : WIN_BASE - 4;
            9: begin a = WIN_BASE + 4 * $urandom_range(1, 3); v = 1'b1; end
            default: ;
         endcase
         do_store(a, rnd128(), m, v);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      rdy_mode = 1;
      drain("rnd");
      chk("rnd_ovf", overflow, m_ovf);

      // asynchronous reset mid-SEND
      rdy_mode = 0;
      repeat (2) @(posedge clk); #1;
      do_store(WIN_BASE, rnd128(), 4'hF, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_valid", sif.out_valid, 1);
      #1 clr = 1'b1;
      #1;
      chk("arst_valid", sif.out_valid, 0);
      chk("arst_level", level, 0);
      chk("arst_ovf", overflow, 0);
      model_reset();
      @(posedge clk); @(posedge clk);
      #1 clr = 1'b0;
      rdy_mode = 1;
      repeat (30) @(posedge clk);
      #1;
      chk("post_rst_valid", sif.out_valid, 0);
      chk("post_rst_level", level, 0);
      do_store(WIN_BASE, rnd128(), 4'hF, 1'b1);
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
